alu_op_sequencer: RTL
=====================

# alu_op_sequencer

Micro-operation sequencer sitting directly upstream of the 8-bit ALU. It holds a small general-purpose register file, accepts one micro-op at a time over a valid/ready handshake, and drives the ALU's A, B and FunSel inputs. It then captures the ALU result and ZCNO flags and writes the result back to a destination register. It is the block that turns register-to-register operations into correctly timed ALU activity, with exactly one evaluation per op.

## Interface
- NREGS, 4, number of general registers (power of two; index width RW = log2(NREGS))
- W, 8, data width; must equal the ALU width
- CLK  in  1  clock; all state changes on rising edge
- RSTn  in  1  reset; asynchronous, active-low
- op_valid  in  1  micro-op offered
- op_ready  out  1  sequencer can accept; high only in IDLE
- op_kind  in  1  0 = ALU op, 1 = load immediate
- op_funsel  in  4  ALU FunSel code for the op
- op_dst, op_srca, op_srcb  in  RW each  destination and source register indices
- op_wb  in  1  1 = write the result to op_dst; 0 = flags only (compare/test)
- op_imm  in  W  immediate for load
- alu_a, alu_b  out  W  ALU operands
- alu_funsel  out  4  ALU function select
- alu_out  in  W  ALU result
- alu_zcno  in  4  ALU flags {Z,C,N,O}
- done  out  1  one-cycle pulse: op retired
- done_result  out  W  result of the retired op, held until the next done
- done_flags  out  4  ZCNO of the last ALU op, held
- dbg_sel  in  RW  register read select
- dbg_data  out  W  combinational read of reg[dbg_sel]

## Operation
- States: IDLE, ISSUE, CAPTURE, DONE.
- **IDLE**
  - op_ready=1.
  - On op_valid&op_ready, latch all op fields.
  - ALU op: go to ISSUE.
  - Load immediate: write op_imm to reg[op_dst] at the accept edge, set done_result=op_imm, go to DONE. done_flags is unchanged.
- **ISSUE**
  - alu_a=reg[srca], alu_b=reg[srcb], alu_funsel=latched funsel.
  - Always go to CAPTURE.
- **CAPTURE**
  - Drive the idle pattern: alu_a=0, alu_b=0, alu_funsel=4'b0000.
  - On the exit edge, sample alu_out into done_result and alu_zcno into done_flags.
  - If wb=1, write alu_out to reg[dst] on the same edge.
  - Go to DONE.
- **DONE**
  - done=1 for this cycle only.
  - Idle pattern on the ALU.
  - Go to IDLE.
- Idle pattern rule: in every state except ISSUE, drive alu_a=0, alu_b=0, alu_funsel=0000.
  - The ALU evaluates on every clock edge and feeds its carry back into ADD and CSR.
  - Holding op inputs for more than one edge would double-apply carry.
  - Pass-A leaves the ALU's carry unchanged; Z and N may change, which is harmless.
- srca, srcb and dst may all alias. Operands are read in ISSUE, before the write in CAPTURE.
- Back-to-back ops: the next op is accepted only in IDLE, after the previous write has landed, so there is no read-after-write hazard.
- The register file has a single write port. The only writes are the accept edge (load) and the CAPTURE exit edge (ALU op); they never coincide.

## Timing
- **Reset (RSTn=0, asynchronous)**
  - State forced to IDLE.
  - All registers, done_result and done_flags go to 0.
  - done=0, op_ready=1 once RSTn is high.
  - ALU outputs take the idle pattern.
- **Reset mid-op:** the in-flight op is dropped, with no write and no done.
- **ALU op:** accept at edge t0.
  - ISSUE is cycle t0..t1; the ALU samples at t1.
  - CAPTURE is t1..t2; result and flags are sampled at t2.
  - done is high t2..t3; op_ready returns at t3.
  - Issue interval: 4 cycles.
- **Load immediate:** write at t0, done high t0..t1, op_ready at t1. Issue interval: 2 cycles.
- op_valid held while op_ready=0 is ignored; fields are latched only at the accept edge.
- dbg_data is combinational and reflects writes the cycle after the writing edge.

## Test plan
- **Reset and load:** RSTn low mid-stream, then load 0x7F→R0 and 0x01→R1. Expect dbg R0=0x7F, R1=0x01; done pulses 1 cycle after each accept; op_ready low for exactly 1 cycle.
- **Overflowing add:** ADD (0100) R0+R1→R2 with ALU carry previously cleared. Expect R2=0x80, done_flags Z=0 C=0 N=1 O=1, done exactly 3 cycles after accept, alu_funsel=0100 for exactly one cycle.
- **Compare without write-back:** load 0x05→R3, then SUB (0101) R3−R3→R3 with wb=0. Expect R3 still 0x05, done_result=0x00, done_flags Z=1 C=0 N=0 O=0.
- **Aliased shift:** load 0x81→R1, LSL (1011) R1→R1. Expect R1=0x02, Z=0 C=1 N=0. Then a second LSL. Expect R1=0x04, C=0.
- **Busy and reset mid-op:** op_valid held continuously. Expect accepts only on IDLE cycles, exactly one ALU op per 4 cycles. Asserting RSTn low during CAPTURE gives no done, destination 0, state IDLE.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Micro-op sequencer in front of the 8-bit ALU: holds a small register file, issues
// one ALU evaluation per accepted op, then captures the result and ZCNO flags.
module alu_op_sequencer #(
    parameter int NREGS = 4,
    parameter int W = 8,
    localparam int RW = $clog2(NREGS)
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic          op_kind,
    input  logic [3:0]    op_funsel,
    input  logic [RW-1:0] op_dst,
    input  logic [RW-1:0] op_srca,
    input  logic [RW-1:0] op_srcb,
    input  logic          op_wb,
    input  logic [W-1:0]  op_imm,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [3:0]    alu_funsel,
    input  logic [W-1:0]  alu_out,
    input  logic [3:0]    alu_zcno,
    output logic          done,
    output logic [W-1:0]  done_result,
    output logic [3:0]    done_flags,
    input  logic [RW-1:0] dbg_sel,
    output logic [W-1:0]  dbg_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} stateT;

    stateT state, nextState;

    logic [W-1:0]  regs [NREGS];
    logic [3:0]    latFunsel;
    logic [RW-1:0] latDst;
    logic [RW-1:0] latSrcA;
    logic [RW-1:0] latSrcB;
    logic          latWb;
    logic          accept;

    assign accept   = op_valid && (state == IDLE);
    assign dbg_data = regs[dbg_sel];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Operands reach the ALU only during ISSUE; every other state drives the pass-A-of-zero
    // pattern so the ALU's fed-back carry is applied exactly once per op.
    always_comb begin
        nextState  = state;
        op_ready   = 1'b0;
        done       = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_funsel = 4'b0000;
        case (state)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    nextState = op_kind ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                alu_a      = regs[latSrcA];
                alu_b      = regs[latSrcB];
                alu_funsel = latFunsel;
                nextState  = CAPTURE;
            end
            CAPTURE: begin
                nextState = DONE;
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            latFunsel <= '0;
            latDst    <= '0;
            latSrcA   <= '0;
            latSrcB   <= '0;
            latWb     <= 1'b0;
        end else if (accept) begin
            latFunsel <= op_funsel;
            latDst    <= op_dst;
            latSrcA   <= op_srca;
            latSrcB   <= op_srcb;
            latWb     <= op_wb;
        end
    end

    // Single write port: load writes at the accept edge, ALU ops at the CAPTURE exit edge.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            done_result <= '0;
            done_flags  <= '0;
        end else if (accept && op_kind) begin
            regs[op_dst] <= op_imm;
            done_result  <= op_imm;
        end else if (state == CAPTURE) begin
            done_result <= alu_out;
            done_flags  <= alu_zcno;
            if (latWb) begin
                regs[latDst] <= alu_out;
            end
        end
    end

endmodule
